// File: rtl/charlie_pkg.sv
// Shared constants for the charlieplexed LED framebuffer blocks.
package charlie_pkg;
   localparam int unsigned N_ROWS   = 7;
   localparam int unsigned N_COLS   = 5;
   localparam int unsigned PWM_BITS = 4;
   localparam int unsigned ADR_W    = 4;
   localparam int unsigned DAT_W    = 8;
   localparam int unsigned IDX_W    = 3;

   localparam logic [ADR_W-1:0] ADR_BACK0  = 4'h0;
   localparam logic [ADR_W-1:0] ADR_BACK1  = 4'h1;
   localparam logic [ADR_W-1:0] ADR_BACK2  = 4'h2;
   localparam logic [ADR_W-1:0] ADR_BACK3  = 4'h3;
   localparam logic [ADR_W-1:0] ADR_BACK4  = 4'h4;
   localparam logic [ADR_W-1:0] ADR_CTRL   = 4'h5;
   localparam logic [ADR_W-1:0] ADR_BRIGHT = 4'h6;
   localparam logic [ADR_W-1:0] ADR_FRAME  = 4'h7;

   localparam logic [PWM_BITS-1:0] BRIGHT_RST = '1;
endpackage

// File: rtl/wb_charlie7x5_fb_if.sv
// Wishbone B4 pipelined slave bus for the framebuffer register file.
interface wb_charlie7x5_fb_if;
   import charlie_pkg::*;

   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic             wb_we_i;
   logic [ADR_W-1:0] wb_adr_i;
   logic [DAT_W-1:0] wb_dat_i;
   logic [DAT_W-1:0] wb_dat_o;
   logic             wb_ack_o;
   logic             wb_stall_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_stall_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_stall_o
   );
endinterface

// File: rtl/charlie_pwm.sv
// Free-running PWM counter with brightness compare; full-scale brightness is always on.
module charlie_pwm
   import charlie_pkg::*;
#(
   parameter int unsigned W = PWM_BITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] bright,
   output logic         on
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
      on    = (bright == '1) | (cnt_q < bright);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_charlie7x5_fb.sv
// Double-buffered 7x5 framebuffer: Wishbone-written back buffer, swap on scanner frame start,
// registered brightness-modulated pixel lookup for the charlieplex scanner.
module wb_charlie7x5_fb
   import charlie_pkg::*;
(
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   wb_charlie7x5_fb_if.slave    wb,
   input  logic [IDX_W-1:0]     scan_row_i,
   input  logic [IDX_W-1:0]     scan_col_i,
   input  logic                 scan_frame_i,
   output logic                 pixel_o
);

   logic [N_COLS-1:0][N_ROWS-1:0] back_q,  back_d;
   logic [N_COLS-1:0][N_ROWS-1:0] front_q, front_d;
   logic                          pending_q, pending_d;
   logic [PWM_BITS-1:0]           bright_q, bright_d;
   logic [DAT_W-1:0]              frame_q, frame_d;
   logic                          ack_q, ack_d;
   logic [DAT_W-1:0]              dat_q, dat_d;
   logic                          pixel_q, pixel_d;

   logic req;
   logic wr;
   logic rd;
   logic pwm_on;

   charlie_pwm #(.W(PWM_BITS)) u_pwm (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .bright (bright_q),
      .on     (pwm_on)
   );

   // Register file, swap and pixel lookup; swap copies the pre-write BACK contents.
   always_comb begin
      req       = wb.wb_cyc_i & wb.wb_stb_i;
      wr        = req & wb.wb_we_i;
      rd        = req & ~wb.wb_we_i;
      back_d    = back_q;
      front_d   = front_q;
      pending_d = pending_q;
      bright_d  = bright_q;
      frame_d   = frame_q;
      ack_d     = req;
      dat_d     = '0;
      pixel_d   = 1'b0;

      if (scan_frame_i) begin
         frame_d = frame_q + DAT_W'(1);
         if (pending_q) begin
            front_d   = back_q;
            pending_d = 1'b0;
         end
      end

      if (wr) begin
         case (wb.wb_adr_i)
            ADR_CTRL:   if (wb.wb_dat_i[0]) pending_d = 1'b1;
            ADR_BRIGHT: bright_d = wb.wb_dat_i[PWM_BITS-1:0];
            default: begin
               for (int c = 0; c < N_COLS; c++) begin
                  if (wb.wb_adr_i == ADR_BACK0 + ADR_W'(c)) back_d[c] = wb.wb_dat_i[N_ROWS-1:0];
               end
            end
         endcase
      end

      if (rd) begin
         case (wb.wb_adr_i)
            ADR_CTRL:   dat_d = DAT_W'(pending_q);
            ADR_BRIGHT: dat_d = DAT_W'(bright_q);
            ADR_FRAME:  dat_d = frame_q;
            default: begin
               for (int c = 0; c < N_COLS; c++) begin
                  if (wb.wb_adr_i == ADR_BACK0 + ADR_W'(c)) dat_d = DAT_W'(back_q[c]);
               end
            end
         endcase
      end

      // Explicit index match so out-of-range row/col naturally yields 0.
      for (int c = 0; c < N_COLS; c++) begin
         for (int r = 0; r < N_ROWS; r++) begin
            if (scan_col_i == IDX_W'(c) && scan_row_i == IDX_W'(r)) pixel_d = front_q[c][r] & pwm_on;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         back_q    <= '0;
         front_q   <= '0;
         pending_q <= 1'b0;
         bright_q  <= BRIGHT_RST;
         frame_q   <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         pixel_q   <= 1'b0;
      end else begin
         back_q    <= back_d;
         front_q   <= front_d;
         pending_q <= pending_d;
         bright_q  <= bright_d;
         frame_q   <= frame_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         pixel_q   <= pixel_d;
      end
   end

   assign wb.wb_ack_o   = ack_q;
   assign wb.wb_dat_o   = dat_q;
   assign wb.wb_stall_o = 1'b0;
   assign pixel_o       = pixel_q;

endmodule

// File: tb/tb_wb_charlie7x5_fb.sv
// Directed-vector bench for wb_charlie7x5_fb with hand-computed expectations.
module tb_wb_charlie7x5_fb;

   logic       clk;
   logic       rst;
   logic [2:0] scan_row;
   logic [2:0] scan_col;
   logic       scan_frame;
   logic       pixel;

   int vectors = 0;
   int miscompares = 0;

   wb_charlie7x5_fb_if bus ();

   wb_charlie7x5_fb dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wb           (bus.slave),
      .scan_row_i   (scan_row),
      .scan_col_i   (scan_col),
      .scan_frame_i (scan_frame),
      .pixel_o      (pixel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic wb_write(input logic [3:0] adr, input logic [7:0] dat, input logic frm);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
      bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  scan_frame = frm;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      scan_frame = 1'b0;
      check($sformatf("wr_ack[%0h]", adr), 32'(bus.wb_ack_o), 32'd1);
   endtask

   task automatic wb_read(input logic [3:0] adr, input logic [7:0] exp, input string tag);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = adr;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      check({tag, "_ack"}, 32'(bus.wb_ack_o), 32'd1);
      check(tag, 32'(bus.wb_dat_o), 32'(exp));
   endtask

   task automatic frame_pulse();
      scan_frame = 1'b1;
      @(posedge clk); #1;
      scan_frame = 1'b0;
   endtask

   task automatic pix(input logic [2:0] r, input logic [2:0] c, input logic exp, input string tag);
      scan_row = r; scan_col = c;
      @(posedge clk); #1;
      check($sformatf("%s(%0d,%0d)", tag, r, c), 32'(pixel), 32'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic count_lit(input int n, output int hits);
      hits = 0;
      scan_row = 3'd0; scan_col = 3'd0;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         hits += int'(pixel);
      end
   endtask

   logic [7:0] rst_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
   int hits;

   initial begin
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
      scan_row = '0; scan_col = '0; scan_frame = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      do_reset();

      // Reset values
      check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
      check("rst_stall", 32'(bus.wb_stall_o), 32'd0);
      for (int a = 0; a < 8; a++) wb_read(4'(a), rst_exp[a], $sformatf("rst_rd%0d", a));
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 8; r++) pix(3'(r), 3'(c), 1'b0, "rst_pix");

      // No swap without CTRL, then swap
      wb_write(4'h0, 8'h7F, 1'b0);
      wb_write(4'h4, 8'h01, 1'b0);
      wb_read(4'h0, 8'h7F, "back0_rd");
      frame_pulse();
      pix(3'd0, 3'd0, 1'b0, "noswap_pix");
      wb_write(4'h5, 8'h01, 1'b0);
      wb_read(4'h5, 8'h01, "ctrl_pending");
      frame_pulse();
      for (int r = 0; r < 7; r++) pix(3'(r), 3'd0, 1'b1, "swap_col0");
      pix(3'd0, 3'd4, 1'b1, "swap_col4");
      pix(3'd1, 3'd4, 1'b0, "swap_col4");
      wb_read(4'h5, 8'h00, "ctrl_cleared");

      // CTRL write coinciding with frame pulse waits for the next pulse
      wb_write(4'h1, 8'h04, 1'b0);
      wb_write(4'h5, 8'h01, 1'b1);
      pix(3'd2, 3'd1, 1'b0, "ctrl_frm_noswap");
      wb_read(4'h5, 8'h01, "ctrl_frm_pending");
      // BACK write in the swap cycle: FRONT takes pre-write value
      wb_write(4'h1, 8'h00, 1'b1);
      pix(3'd2, 3'd1, 1'b1, "swap_prewrite");
      wb_read(4'h1, 8'h00, "back1_postwrite");
      wb_read(4'h5, 8'h00, "ctrl_after_swap");
      // Pending request consumed and re-set by a simultaneous CTRL write
      wb_write(4'h5, 8'h01, 1'b0);
      wb_write(4'h5, 8'h01, 1'b1);
      pix(3'd2, 3'd1, 1'b0, "reswap_pix");
      wb_read(4'h5, 8'h01, "ctrl_reset_by_wr");
      frame_pulse();
      wb_read(4'h5, 8'h00, "ctrl_final");
      wb_write(4'h5, 8'h00, 1'b0);
      wb_read(4'h5, 8'h00, "ctrl_wr0");

      // FRONT all 0x7F, boundaries, then brightness
      for (int c = 0; c < 5; c++) wb_write(4'(c), 8'hFF, 1'b0);
      wb_read(4'h2, 8'h7F, "bit7_ignored");
      wb_write(4'h5, 8'h01, 1'b0);
      frame_pulse();
      pix(3'd6, 3'd4, 1'b1, "full_corner");
      pix(3'd7, 3'd0, 1'b0, "row_oob");
      pix(3'd0, 3'd5, 1'b0, "col_oob");
      pix(3'd7, 3'd7, 1'b0, "both_oob");
      wb_write(4'h6, 8'hF4, 1'b0);
      wb_read(4'h6, 8'h04, "bright_rd");
      count_lit(16, hits);
      check("bright4_16", 32'(hits), 32'd4);
      count_lit(32, hits);
      check("bright4_32", 32'(hits), 32'd8);
      wb_write(4'h6, 8'h00, 1'b0);
      count_lit(16, hits);
      check("bright0", 32'(hits), 32'd0);
      wb_write(4'h6, 8'h0F, 1'b0);
      count_lit(16, hits);
      check("brightF", 32'(hits), 32'd16);

      // Frame counter wrap, unmapped, back-to-back
      do_reset();
      for (int i = 0; i < 257; i++) frame_pulse();
      wb_read(4'h7, 8'h01, "frame_257");
      wb_write(4'h7, 8'h55, 1'b0);
      wb_read(4'h7, 8'h01, "frame_ro");
      wb_write(4'h9, 8'hFF, 1'b0);
      wb_read(4'h9, 8'h00, "unmapped_rd");
      wb_read(4'hF, 8'h00, "unmapped_rdF");
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 4'h6;
      @(posedge clk); #1;
      check("b2b_ack1", 32'(bus.wb_ack_o), 32'd1);
      check("b2b_dat1", 32'(bus.wb_dat_o), 32'h0F);
      check("b2b_stall", 32'(bus.wb_stall_o), 32'd0);
      bus.wb_adr_i = 4'h7;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      check("b2b_ack2", 32'(bus.wb_ack_o), 32'd1);
      check("b2b_dat2", 32'(bus.wb_dat_o), 32'h01);
      @(posedge clk); #1;
      check("b2b_idle", 32'(bus.wb_ack_o), 32'd0);

      // Reset with a strobe outstanding
      wb_write(4'h0, 8'h55, 1'b0);
      wb_write(4'h5, 8'h01, 1'b0);
      frame_pulse();
      wb_write(4'h1, 8'h22, 1'b0);
      wb_write(4'h6, 8'h0F, 1'b0);
      wb_write(4'h5, 8'h01, 1'b0);
      pix(3'd0, 3'd0, 1'b1, "pre_rst_pix");
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 4'h0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
      check("midrst_pix", 32'(pixel), 32'd0);
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("postrst_ack", 32'(bus.wb_ack_o), 32'd0);
      for (int a = 0; a < 8; a++) wb_read(4'(a), rst_exp[a], $sformatf("postrst_rd%0d", a));
      pix(3'd0, 3'd0, 1'b0, "postrst_pix");
      pix(3'd2, 3'd0, 1'b0, "postrst_pix");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_charlie7x5_fb.md
# wb_charlie7x5_fb

Wishbone-writable double-buffered framebuffer for the 7x5 charlieplexed LED display. It sits directly upstream of the charlieplex scanner. The CPU writes a back buffer of five 7-bit columns and requests a swap. The scanner presents its current (row, col) each cycle and receives a registered, brightness-modulated pixel bit. Swaps occur only on the scanner's frame-start pulse, so the display never tears.

## Interface
Parameters:
- N_ROWS, 7, pixel rows per column; the legal row index range is 0..N_ROWS-1.
- N_COLS, 5, columns held in the buffer.
- PWM_BITS, 4, width of the brightness register and the PWM counter.

Ports:
- wb_clk_i  in  1  the single clock for the block.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_cyc_i  in  1  Wishbone B4 pipelined cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  4  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, valid with ack.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  tied 0.
- scan_row_i  in  3  row currently driven by the scanner.
- scan_col_i  in  3  column currently driven by the scanner.
- scan_frame_i  in  1  one-cycle pulse at the start of each scan frame.
- pixel_o  out  1  lit/unlit for the (row, col) presented on the previous cycle.

## Operation
Register map (8-bit):
- 0x0–0x4 BACK[c], read/write. Bit r is pixel (row r, col c). Bit 7 is ignored on write and reads 0.
- 0x5 CTRL. Writing bit0=1 sets swap_pending; writing 0 has no effect. A read returns {7'b0, swap_pending}.
- 0x6 BRIGHT, read/write, bits [3:0]; the upper bits read 0.
- 0x7 FRAME, read-only, 8-bit count of scan_frame_i pulses. It wraps from 0xFF to 0x00.
- 0x8–0xF are unmapped: reads return 0, writes are dropped, and the access is still acked.

Swap:
- When scan_frame_i=1 and swap_pending=1, FRONT[0..4] takes BACK[0..4] and swap_pending clears, both in the same cycle.
- A BACK write in the swap cycle lands in BACK only. FRONT receives the pre-write value.
- A CTRL swap write coinciding with scan_frame_i sets swap_pending after the evaluation. That request waits for the next frame pulse. A request already pending in that cycle is consumed and re-set by the write.
- FRAME increments on every scan_frame_i pulse, whether or not a swap occurs.

Pixel path:
- The free-running PWM counter pwm_cnt (PWM_BITS wide) increments every cycle and wraps.
- on = (BRIGHT==4'hF) | (pwm_cnt < BRIGHT). BRIGHT=0 means always off; BRIGHT=0xF means always on.
- pixel_o <= FRONT[scan_col_i][scan_row_i] & on.
- Out-of-range indices (col≥5 or row≥7) give pixel_o <= 0.

Reset values:
- BACK = 0, FRONT = 0, swap_pending = 0, BRIGHT = 0xF, FRAME = 0, pwm_cnt = 0.
- Outputs: wb_ack_o = 0, wb_dat_o = 0, pixel_o = 0.

## Timing
- The bus never stalls. wb_ack_o is registered and asserts exactly one cycle after each cycle with cyc&stb, so back-to-back strobes give back-to-back acks. wb_dat_o is registered in the same cycle as the ack.
- A register write takes effect at the edge where stb is sampled. A read in the following cycle returns the new value.
- pixel_o latency is 1 cycle from the scan_row_i/scan_col_i inputs.
- FRONT is visible on pixel_o starting with the lookup presented in the cycle after the swap edge.
- Reset asserted mid-transaction forces wb_ack_o=0 on the next edge. Any strobe sampled during reset is dropped without an ack.

## Structure
- Shared package charlie_pkg holds:
  - N_ROWS, N_COLS, PWM_BITS;
  - the register addresses ADR_BACK0..ADR_BACK4, ADR_CTRL, ADR_BRIGHT, ADR_FRAME;
  - the BRIGHT reset value.
- One sub-module, charlie_pwm: the PWM counter plus the compare, with input bright and output on. It is reusable by other LED blocks.
- The register file, swap logic and Wishbone slave stay in the top module.

## Test plan
- Reset, then read 0x0–0x7 → 00,00,00,00,00,00,0F,00. After reset, pixel_o=0 for all (row, col).
- Write BACK0=0x7F and BACK4=0x01, do not set CTRL, pulse scan_frame_i → pixel_o stays 0 at (0,0). Then write CTRL=1 and pulse scan_frame_i → pixel_o=1 at (r,0) for r=0..6, pixel_o=1 at (0,4), pixel_o=0 at (1,4). CTRL reads 0 afterwards.
- Write CTRL=1 in the same cycle as a scan_frame_i pulse → no swap occurs and CTRL reads 1. The next pulse swaps and CTRL reads 0.
- With FRONT all 0x7F, scan (0,0) continuously:
  - BRIGHT=4 → pixel_o high for 4 of every 16 cycles;
  - BRIGHT=0 → pixel_o never high;
  - BRIGHT=0xF → pixel_o always high.
- Give 257 scan_frame_i pulses → FRAME reads 0x01. A read of 0x9 → 0x00 with ack. Two back-to-back strobes → two consecutive acks with no stall.
- Assert reset while a strobe is outstanding → no ack on the next cycle, all registers return to their reset values, and pixel_o=0.
